// File: rtl/bloom_pkg.sv
// Shared definitions for the Avalon-ST packet arbiter: symbol width, empty-field sizing
// and the arbiter FSM state type.
package bloom_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    StIdle,
    StPkt
  } arb_state_e;

  // Avalon-ST empty field is at least one bit wide even for single-symbol beats.
  function automatic int unsigned empty_w(input int unsigned symbols);
    return (symbols == 1) ? 1 : $clog2(symbols);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: returns the first set request at or after base,
// wrapping modulo N.
module rr_picker #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] base,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int unsigned IdxW = $clog2(N);

  always_comb begin
    int unsigned cand;
    logic [IdxW-1:0] cand_idx;
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand     = (32'(base) + off) % N;
      cand_idx = IdxW'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/ast_pkt_arbiter.sv
// Round-robin packet arbiter merging NUM_SRC Avalon-ST sources onto one stream; the grant
// is held for a whole packet and re-arbitrated with a one-cycle bubble after each eop.
module ast_pkt_arbiter
  import bloom_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned AST_SYMBOLS = 8,
  parameter int unsigned AST_EMPTY_W = empty_w(AST_SYMBOLS)
) (
  input  logic                                        clk_i,
  input  logic                                        srst_i,
  input  logic [NUM_SRC-1:0][AST_SYMBOLS*BYTE_W-1:0]  src_data_i,
  input  logic [NUM_SRC-1:0]                          src_valid_i,
  input  logic [NUM_SRC-1:0][AST_EMPTY_W-1:0]         src_empty_i,
  input  logic [NUM_SRC-1:0]                          src_sop_i,
  input  logic [NUM_SRC-1:0]                          src_eop_i,
  output logic [NUM_SRC-1:0]                          src_ready_o,
  output logic [AST_SYMBOLS*BYTE_W-1:0]               ast_data_o,
  output logic                                        ast_valid_o,
  output logic [AST_EMPTY_W-1:0]                      ast_empty_o,
  output logic                                        ast_sop_o,
  output logic                                        ast_eop_o,
  input  logic                                        ast_ready_i,
  output logic [$clog2(NUM_SRC)-1:0]                  grant_o,
  output logic                                        busy_o,
  output logic                                        sop_err_o
);

  localparam int unsigned GrantW = $clog2(NUM_SRC);

  arb_state_e        state_q;
  logic [GrantW-1:0] grant_q;
  logic [GrantW-1:0] last_grant_q;
  logic              first_beat_q;

  logic [GrantW-1:0] base;
  logic              pick_found;
  logic [GrantW-1:0] pick_idx;
  logic              in_pkt;
  logic              beat_acc;

  assign base = (last_grant_q == GrantW'(NUM_SRC - 1)) ? '0 : last_grant_q + 1'b1;

  rr_picker #(
    .N (NUM_SRC)
  ) u_picker (
    .req   (src_valid_i),
    .base  (base),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Gating with srst_i drops the in-flight packet the moment reset is seen.
  assign in_pkt   = (state_q == StPkt) && !srst_i;
  assign beat_acc = ast_valid_o && ast_ready_i;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= GrantW'(NUM_SRC - 1);
      first_beat_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pick_found) begin
            grant_q      <= pick_idx;
            first_beat_q <= 1'b1;
            state_q      <= StPkt;
          end
        end
        StPkt: begin
          if (beat_acc) begin
            first_beat_q <= 1'b0;
            if (src_eop_i[grant_q]) begin
              last_grant_q <= grant_q;
              state_q      <= StIdle;
            end
          end
        end
      endcase
    end
  end

  assign ast_data_o  = src_data_i[grant_q];
  assign ast_empty_o = src_empty_i[grant_q];
  assign ast_sop_o   = src_sop_i[grant_q];
  assign ast_eop_o   = src_eop_i[grant_q];
  assign ast_valid_o = in_pkt && src_valid_i[grant_q];

  always_comb begin
    src_ready_o = '0;
    if (in_pkt) begin
      src_ready_o[grant_q] = ast_ready_i;
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = in_pkt;
  assign sop_err_o = beat_acc && first_beat_q && !src_sop_i[grant_q];

endmodule
